// File: rtl/opensync_rx_ts_corrector.sv
// opensync_rx_ts_corrector
// Receive-side OpenSync timestamp corrector for one port's byte stream.
// Every byte goes through a fixed {valid,byte} delay line plus an output
// register, so the output is the input delayed by PIPE_DEPTH+1 cycles.
// The sync and local clocks are sampled at each frame's first byte. When a
// frame's match field equals MATCH_VALUE, its big-endian TX timestamp is
// captured and corr = syn - (loc - ts) + link_delay is computed. While the
// frame is still in the delay line, corr is written over its bytes
// CORR_OFFSET..CORR_OFFSET+TS_BYTES-1.
// The match field is only seen from byte 1 on, so MATCH_OFFSET must be >= 1.
// After reset, input is ignored until i_data_wr has been low once. This drops
// any frame that was cut by the reset.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   iv_syn_clk, iv_local_time global time and local time, sampled at byte 0
//   iv_link_delay             link delay added to the correction
//   i_corr_en                 correction enable, sampled at byte 0
//   iv_data, i_data_wr        RX byte stream
//   ov_data, o_data_wr        TX byte stream
//   o_corr_pulse              one-cycle pulse when corr is computed
//   ov_corr_cnt, ov_short_cnt corrected frames and short matched frames (wrap)
module opensync_rx_ts_corrector #(
   parameter int unsigned PIPE_DEPTH   = 16,
   parameter int unsigned TS_BYTES     = 8,
   parameter int unsigned MATCH_OFFSET = 12,
   parameter logic [31:0] MATCH_VALUE  = 32'hFF01_0603,
   parameter int unsigned TS_OFFSET    = 24,
   parameter int unsigned CORR_OFFSET  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [8*TS_BYTES-1:0]   iv_syn_clk,
   input  logic [8*TS_BYTES-1:0]   iv_local_time,
   input  logic [8*TS_BYTES-1:0]   iv_link_delay,
   input  logic                    i_corr_en,
   input  logic [7:0]              iv_data,
   input  logic                    i_data_wr,
   output logic [7:0]              ov_data,
   output logic                    o_data_wr,
   output logic                    o_corr_pulse,
   output logic [15:0]             ov_corr_cnt,
   output logic [15:0]             ov_short_cnt
);

   localparam int unsigned TS_W  = 8 * TS_BYTES;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, MATCH, CAPTURE, PASS} state_t;

   state_t           state;
   logic             armed;
   logic             in_vld_c;
   logic [CNT_W-1:0] in_cnt;
   logic [TS_W-1:0]  rx_syn, rx_loc, ts, corr;
   logic             corr_pending;

   logic [7:0]            pipe_data [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] pipe_vld;
   logic                  pipe_end_vld_c;
   logic [7:0]            pipe_end_data_c;
   logic [CNT_W-1:0]      out_cnt;

   logic            match_in_win_c, match_eq_c, match_last_c;
   logic            ts_in_win_c, ts_last_c;
   logic [TS_W-1:0] ts_next_c, corr_next_c;
   logic            rep_hit_c, rep_last_c;
   logic [7:0]      rep_byte_c, out_byte_c;

   assign in_vld_c        = i_data_wr & armed;
   assign pipe_end_vld_c  = pipe_vld[PIPE_DEPTH-1];
   assign pipe_end_data_c = pipe_data[PIPE_DEPTH-1];

   // Input-side decode: position of the current byte in the match field
   always_comb begin
      match_in_win_c = 1'b0;
      match_eq_c     = 1'b0;
      match_last_c   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (in_cnt == CNT_W'(MATCH_OFFSET + k)) begin
            match_in_win_c = 1'b1;
            match_eq_c     = (iv_data == MATCH_VALUE[8*(3-k) +: 8]);
            match_last_c   = (k == 3);
         end
      end
   end

   assign ts_in_win_c = (in_cnt >= CNT_W'(TS_OFFSET)) &&
                        (in_cnt <= CNT_W'(TS_OFFSET + TS_BYTES - 1));
   assign ts_last_c   = (in_cnt == CNT_W'(TS_OFFSET + TS_BYTES - 1));
   assign ts_next_c   = TS_W'({ts, iv_data});
   assign corr_next_c = rx_syn - (rx_loc - ts_next_c) + iv_link_delay;

   // Output-side decode: the corr byte for the byte leaving the delay line
   always_comb begin
      rep_hit_c  = 1'b0;
      rep_last_c = 1'b0;
      rep_byte_c = 8'h00;
      for (int k = 0; k < int'(TS_BYTES); k++) begin
         if (out_cnt == CNT_W'(CORR_OFFSET + k)) begin
            rep_hit_c  = 1'b1;
            rep_byte_c = corr[8*(int'(TS_BYTES)-1-k) +: 8];
            rep_last_c = (k == int'(TS_BYTES) - 1);
         end
      end
   end

   assign out_byte_c = (corr_pending && rep_hit_c) ? rep_byte_c : pipe_end_data_c;

   // Delay line, output register and output byte counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe_data[i] <= 8'h00;
         pipe_vld  <= '0;
         o_data_wr <= 1'b0;
         ov_data   <= 8'h00;
         out_cnt   <= '0;
      end else begin
         pipe_data[0] <= in_vld_c ? iv_data : 8'h00;
         for (int i = 1; i < int'(PIPE_DEPTH); i++) pipe_data[i] <= pipe_data[i-1];
         pipe_vld  <= {pipe_vld[PIPE_DEPTH-2:0], in_vld_c};
         o_data_wr <= pipe_end_vld_c;
         ov_data   <= pipe_end_vld_c ? out_byte_c : 8'h00;
         if (!pipe_end_vld_c)      out_cnt <= '0;
         else if (out_cnt != CNT_MAX) out_cnt <= out_cnt + CNT_W'(1);
      end
   end

   // Input byte counter; arming waits for one idle cycle after reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         armed  <= 1'b0;
         in_cnt <= '0;
      end else begin
         if (!i_data_wr) armed <= 1'b1;
         if (!in_vld_c)              in_cnt <= '0;
         else if (in_cnt != CNT_MAX) in_cnt <= in_cnt + CNT_W'(1);
      end
   end

   // Input FSM, correction value, pending flag and statistics
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         rx_syn       <= '0;
         rx_loc       <= '0;
         ts           <= '0;
         corr         <= '0;
         corr_pending <= 1'b0;
         o_corr_pulse <= 1'b0;
         ov_corr_cnt  <= '0;
         ov_short_cnt <= '0;
      end else begin
         o_corr_pulse <= 1'b0;
         // A new corr (set below) takes priority over clearing the old one
         if (!pipe_end_vld_c || (rep_hit_c && rep_last_c)) corr_pending <= 1'b0;
         case (state)
            IDLE: begin
               if (in_vld_c) begin
                  rx_syn <= iv_syn_clk;
                  rx_loc <= iv_local_time;
                  ts     <= '0;
                  state  <= i_corr_en ? MATCH : PASS;
               end
            end
            MATCH: begin
               if (!in_vld_c) begin
                  state <= IDLE;
               end else if (match_in_win_c) begin
                  if (!match_eq_c)       state <= PASS;
                  else if (match_last_c) state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (!in_vld_c) begin
                  ov_short_cnt <= ov_short_cnt + 16'd1;
                  state        <= IDLE;
               end else if (ts_in_win_c) begin
                  ts <= ts_next_c;
                  if (ts_last_c) begin
                     corr         <= corr_next_c;
                     corr_pending <= 1'b1;
                     o_corr_pulse <= 1'b1;
                     ov_corr_cnt  <= ov_corr_cnt + 16'd1;
                     state        <= PASS;
                  end
               end
            end
            PASS: begin
               if (!in_vld_c) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_opensync_rx_ts_corrector.sv
// Bench for opensync_rx_ts_corrector. Each frame's expected output is built
// from the byte-level rules before the frame is sent. The monitor then checks
// every output cycle against the input timeline delayed by 17 cycles.
module tb_opensync_rx_ts_corrector;

   localparam int LAT = 17;
   localparam int N   = 16384;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [63:0] iv_syn_clk, iv_local_time, iv_link_delay;
   logic        i_corr_en;
   logic [7:0]  iv_data;
   logic        i_data_wr;
   logic [7:0]  ov_data;
   logic        o_data_wr, o_corr_pulse;
   logic [15:0] ov_corr_cnt, ov_short_cnt;

   opensync_rx_ts_corrector dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .iv_syn_clk(iv_syn_clk), .iv_local_time(iv_local_time),
      .iv_link_delay(iv_link_delay), .i_corr_en(i_corr_en),
      .iv_data(iv_data), .i_data_wr(i_data_wr),
      .ov_data(ov_data), .o_data_wr(o_data_wr), .o_corr_pulse(o_corr_pulse),
      .ov_corr_cnt(ov_corr_cnt), .ov_short_cnt(ov_short_cnt)
   );

   always #4 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   bit         exp_wr    [N];
   logic [7:0] exp_data  [N];
   bit         exp_pulse [N];

   int          checks = 0, errors = 0;
   int          m_corr = 0, m_short = 0;
   int          last_start = 0;
   bit          mon_en = 1'b0;
   int          out_idx = 0;
   logic [63:0] obs_corr = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output monitor; also collects bytes 16..23 of each output frame
   always @(negedge i_clk) begin
      if (mon_en && cyc >= LAT && cyc < N) begin
         chk("out_wr",   64'(o_data_wr),    64'(exp_wr[cyc-LAT]));
         chk("out_data", 64'(ov_data),      64'(exp_data[cyc-LAT]));
         chk("pulse",    64'(o_corr_pulse), 64'(exp_pulse[cyc]));
         if (o_data_wr) begin
            if (out_idx >= 16 && out_idx <= 23) obs_corr = {obs_corr[55:0], ov_data};
            out_idx++;
         end else begin
            out_idx = 0;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge i_clk);
         i_data_wr = 1'b0;
         iv_data   = 8'h00;
      end
   endtask

   // Builds one frame, predicts its output, and drives the first 'cut' bytes
   task automatic send_frame(input int len, input bit match, input bit bad13, input bit en,
                             input logic [63:0] syn, input logic [63:0] loc,
                             input logic [63:0] ts, input logic [63:0] dly,
                             input int gap, input int cut);
      logic [7:0]  f[$];
      logic [7:0]  e[$];
      logic [63:0] tsv, c;
      bit          ok, hit;
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      if (match && len > 15) begin
         f[12] = 8'hFF; f[13] = 8'h01; f[14] = 8'h06; f[15] = 8'h03;
      end
      if (bad13 && len > 13) f[13] = 8'h02;
      for (int k = 0; k < 8; k++) if (24 + k < len) f[24+k] = ts[8*(7-k) +: 8];
      e   = f;
      hit = 1'b0;
      ok  = en && len >= 16 && f[12] == 8'hFF && f[13] == 8'h01 &&
            f[14] == 8'h06 && f[15] == 8'h03;
      if (cut == len && ok) begin
         if (len >= 32) begin
            tsv = '0;
            for (int k = 0; k < 8; k++) tsv = {tsv[55:0], f[24+k]};
            c = syn - (loc - tsv) + dly;
            for (int k = 0; k < 8; k++) e[16+k] = c[8*(7-k) +: 8];
            m_corr++;
            hit = 1'b1;
         end else begin
            m_short++;
         end
      end
      for (int i = 0; i < cut; i++) begin
         @(negedge i_clk);
         if (i == 0) begin
            last_start    = cyc;
            iv_syn_clk    = syn;
            iv_local_time = loc;
            iv_link_delay = dly;
            i_corr_en     = en;
         end
         i_data_wr = 1'b1;
         iv_data   = f[i];
         if (cyc < N - 1) begin
            exp_wr[cyc]   = 1'b1;
            exp_data[cyc] = e[i];
            if (hit && i == 31) exp_pulse[cyc+1] = 1'b1;
         end
      end
      if (gap > 0) idle(gap);
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      for (int i = 0; i < N; i++) exp_data[i] = 8'h00;
      i_rst_n = 1'b0; i_data_wr = 1'b0; iv_data = 8'h00; i_corr_en = 1'b0;
      iv_syn_clk = '0; iv_local_time = '0; iv_link_delay = '0;
      repeat (3) @(negedge i_clk);
      chk("rst_wr",    64'(o_data_wr),    64'd0);
      chk("rst_data",  64'(ov_data),      64'd0);
      chk("rst_pulse", 64'(o_corr_pulse), 64'd0);
      chk("rst_ccnt",  64'(ov_corr_cnt),  64'd0);
      chk("rst_scnt",  64'(ov_short_cnt), 64'd0);
      i_rst_n = 1'b1;
      mon_en  = 1'b1;
      idle(3);

      // basic match
      send_frame(64, 1, 0, 1, 64'h5000, 64'h3000, 64'h1000, 64'h10, 1, 64);
      idle(25);
      chk("t1_corr", obs_corr, 64'h3010);
      chk("t1_ccnt", 64'(ov_corr_cnt), 64'(16'(m_corr)));

      // wraparound arithmetic
      send_frame(64, 1, 0, 1, 64'h10, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 64);
      idle(25);
      chk("t2_corr", obs_corr, 64'hA);

      // mismatch and disabled correction
      send_frame(64, 1, 1, 1, r64(), r64(), r64(), r64(), 2, 64);
      send_frame(64, 1, 0, 0, r64(), r64(), r64(), r64(), 2, 64);
      idle(25);
      chk("t3_ccnt", 64'(ov_corr_cnt), 64'(16'(m_corr)));
      chk("t3_scnt", 64'(ov_short_cnt), 64'(16'(m_short)));

      // short matched frame
      send_frame(28, 1, 0, 1, r64(), r64(), r64(), r64(), 2, 28);
      idle(25);
      chk("t4_scnt", 64'(ov_short_cnt), 64'(16'(m_short)));
      chk("t4_ccnt", 64'(ov_corr_cnt), 64'(16'(m_corr)));

      // back-to-back with one-cycle gap
      send_frame(40, 1, 0, 1, r64(), r64(), r64(), r64(), 1, 40);
      send_frame(40, 1, 0, 1, r64(), r64(), r64(), r64(), 1, 40);
      idle(25);
      chk("t5_ccnt", 64'(ov_corr_cnt), 64'(16'(m_corr)));

      // randomized frames
      for (int n = 0; n < 40; n++) begin
         int len;
         len = $urandom_range(8, 90);
         send_frame(len, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) != 0, r64(), r64(), r64(), r64(),
                    $urandom_range(1, 4), len);
      end
      idle(25);
      chk("rnd_ccnt", 64'(ov_corr_cnt), 64'(16'(m_corr)));
      chk("rnd_scnt", 64'(ov_short_cnt), 64'(16'(m_short)));

      // reset in the middle of a matching frame (at input byte 20)
      send_frame(64, 1, 0, 1, r64(), r64(), r64(), r64(), 0, 20);
      @(negedge i_clk);
      #2;
      for (int c = last_start; c <= cyc && c < N; c++) begin
         exp_wr[c] = 1'b0; exp_data[c] = 8'h00; exp_pulse[c] = 1'b0;
      end
      i_rst_n = 1'b0; i_data_wr = 1'b0; iv_data = 8'h00;
      m_corr = 0; m_short = 0;
      #1;
      chk("mid_rst_wr",    64'(o_data_wr),    64'd0);
      chk("mid_rst_data",  64'(ov_data),      64'd0);
      chk("mid_rst_ccnt",  64'(ov_corr_cnt),  64'd0);
      chk("mid_rst_scnt",  64'(ov_short_cnt), 64'd0);
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      idle(3);
      send_frame(64, 1, 0, 1, 64'h5000, 64'h3000, 64'h1000, 64'h10, 1, 64);
      idle(25);
      chk("t6_corr", obs_corr, 64'h3010);
      chk("t6_ccnt", 64'(ov_corr_cnt), 64'd1);
      chk("t6_scnt", 64'(ov_short_cnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
